// File: rtl/fu_scheduler.sv
// Issue/hazard controller for the shared iterative MUL/DIV unit beside DE.
// Tracks one in-flight FU destination and raises structural/RAW/WAW stalls.
module fu_scheduler #(
   parameter int REGIDX  = 5,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 16,
   parameter int CNTW    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              de_valid,
   input  logic              de_is_fu,
   input  logic              de_op,
   input  logic [REGIDX-1:0] de_rd,
   input  logic              de_rd_we,
   input  logic [REGIDX-1:0] de_rs1,
   input  logic              de_rs1_use,
   input  logic [REGIDX-1:0] de_rs2,
   input  logic              de_rs2_use,
   input  logic              flush,
   output logic              stall,
   output logic              fu_issue,
   output logic              fu_op,
   output logic [REGIDX-1:0] fu_rd,
   output logic              fu_busy,
   output logic              fu_complete,
   output logic [CNTW-1:0]   stall_cycles
);

   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [REGIDX-1:0] busy_rd;
   logic              busy_we;
   logic              req, hz_en, raw, waw, strct, issue_ok;

   // busy_we is never set for x0, so register 0 cannot hazard.
   assign hz_en = fu_busy & busy_we;
   assign raw   = hz_en & ((de_rs1_use & (de_rs1 == busy_rd)) |
                           (de_rs2_use & (de_rs2 == busy_rd)));
   assign waw   = hz_en & de_rd_we & (de_rd == busy_rd);
   assign strct = de_is_fu & (state == BUSY);
   assign req   = de_valid & ~flush;

   assign stall    = req & (raw | waw | strct);
   assign issue_ok = req & de_is_fu & ~raw & ~waw & ((state == IDLE) | (state == DONE));
   assign fu_issue = issue_ok;
   assign fu_op    = de_op;

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (issue_ok) begin
               state_nxt = BUSY;
               cnt_nxt   = de_op ? DIV_LOAD : MUL_LOAD;
            end
         end
         BUSY: begin
            if (cnt != '0) cnt_nxt   = cnt - CNT_W'(1);
            else           state_nxt = DONE;
         end
         DONE: begin
            // Back-to-back issue is allowed in the completion cycle.
            if (issue_ok) begin
               state_nxt = BUSY;
               cnt_nxt   = de_op ? DIV_LOAD : MUL_LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: non-blocking assignments for all sequential state.
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         busy_rd      <= '0;
         busy_we      <= 1'b0;
         fu_rd        <= '0;
         fu_busy      <= 1'b0;
         fu_complete  <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         fu_busy     <= (state_nxt != IDLE);
         fu_complete <= (state_nxt == DONE);
         if (issue_ok) begin
            busy_rd <= de_rd;
            busy_we <= de_rd_we & (de_rd != '0);
            fu_rd   <= de_rd;
         end
         if (stall) stall_cycles <= stall_cycles + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_fu_scheduler.sv
// Self-checking bench for fu_scheduler: a timestamp-based model of the single
// in-flight FU op checked every cycle, plus directed scenarios with literal expectations.
module tb_fu_scheduler;

   logic        clk, reset;
   logic        de_valid, de_is_fu, de_op, de_rd_we, de_rs1_use, de_rs2_use, flush;
   logic [4:0]  de_rd, de_rs1, de_rs2;
   logic        stall, fu_issue, fu_op, fu_busy, fu_complete;
   logic [4:0]  fu_rd;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   fu_scheduler dut (
      .clk(clk), .reset(reset),
      .de_valid(de_valid), .de_is_fu(de_is_fu), .de_op(de_op),
      .de_rd(de_rd), .de_rd_we(de_rd_we),
      .de_rs1(de_rs1), .de_rs1_use(de_rs1_use),
      .de_rs2(de_rs2), .de_rs2_use(de_rs2_use),
      .flush(flush),
      .stall(stall), .fu_issue(fu_issue), .fu_op(fu_op), .fu_rd(fu_rd),
      .fu_busy(fu_busy), .fu_complete(fu_complete), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: one op record with issue timestamp and latency; outputs derived from time.
   bit          m_active;
   int          m_issue, m_lat;
   logic [4:0]  m_rd, m_fu_rd;
   bit          m_we;
   logic [31:0] m_stalls;

   always @(negedge clk) begin
      bit busy, done, hz, raw, waw, req, e_stall, e_issue;
      if (!reset) begin
         m_active = 0;
         m_fu_rd  = '0;
         m_stalls = '0;
      end else begin
         busy = m_active && (cyc > m_issue) && (cyc <= m_issue + m_lat);
         done = busy && (cyc == m_issue + m_lat);
         req  = de_valid && !flush;
         hz   = busy && m_we;
         raw  = hz && ((de_rs1_use && de_rs1 == m_rd) || (de_rs2_use && de_rs2 == m_rd));
         waw  = hz && de_rd_we && (de_rd == m_rd);
         e_stall = req && (raw || waw || (de_is_fu && busy && !done));
         e_issue = req && de_is_fu && !raw && !waw && (!busy || done);
         check("stall", stall, e_stall);
         check("fu_issue", fu_issue, e_issue);
         check("fu_busy", fu_busy, busy);
         check("fu_complete", fu_complete, done);
         check("fu_rd", fu_rd, m_fu_rd);
         check("stall_cycles", stall_cycles, m_stalls);
         if (e_issue) check("fu_op", fu_op, de_op);
         if (e_stall) m_stalls = m_stalls + 1;
         if (e_issue) begin
            m_active = 1;
            m_issue  = cyc;
            m_lat    = de_op ? 16 : 3;
            m_rd     = de_rd;
            m_we     = de_rd_we && (de_rd != 0);
            m_fu_rd  = de_rd;
         end
      end
   end

   // Inputs change 1 time unit after the rising edge.
   task automatic drive(input bit v, input bit fu, input bit op, input logic [4:0] rd,
                        input bit we, input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2, input bit fl);
      @(posedge clk);
      #1;
      de_valid = v;  de_is_fu = fu;  de_op = op;  de_rd = rd;  de_rd_we = we;
      de_rs1 = r1;   de_rs1_use = u1; de_rs2 = r2; de_rs2_use = u2; flush = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
   endtask

   task automatic issue_fu(input bit op, input logic [4:0] rd, input logic [4:0] r1,
                           input logic [4:0] r2, input bit fl);
      drive(1, 1, op, rd, 1, r1, 1, r2, 1, fl);
   endtask

   task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit fl);
      drive(1, 0, 0, rd, 1, r1, 1, r2, 1, fl);
   endtask

   // Hold the current DE instruction until stall drops; n = stalled cycles.
   task automatic wait_accept(input int max, output int n);
      n = 0;
      #1;
      while (stall && n < max) begin
         n++;
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      de_valid = 0; de_is_fu = 0; de_op = 0; de_rd = '0; de_rd_we = 0;
      de_rs1 = '0; de_rs1_use = 0; de_rs2 = '0; de_rs2_use = 0; flush = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      reset = 1'b1;
      de_valid = 0; de_is_fu = 0; de_op = 0; de_rd = '0; de_rd_we = 0;
      de_rs1 = '0; de_rs1_use = 0; de_rs2 = '0; de_rs2_use = 0; flush = 0;
      #1 reset = 1'b0;
      #2;
      check("rst fu_busy", fu_busy, 0);
      check("rst fu_complete", fu_complete, 0);
      check("rst fu_rd", fu_rd, 0);
      check("rst stall_cycles", stall_cycles, 0);
      check("rst stall", stall, 0);
      check("rst fu_issue", fu_issue, 0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) idle();

      // Single MUL rd=5: busy for 3 cycles, completes 3 cycles after issue.
      issue_fu(0, 5'd5, 5'd1, 5'd2, 0);
      #1 check("A issue", fu_issue, 1);
      check("A op", fu_op, 0);
      idle(); #1 check("A busy c1", fu_busy, 1);
      idle(); #1 check("A busy c2", fu_busy, 1);
      idle(); #1 check("A complete c3", fu_complete, 1);
      check("A rd c3", fu_rd, 5);
      idle(); #1 check("A idle c4", fu_busy, 0);
      check("A no stall", stall_cycles, 0);

      // RAW on DIV rd=7: dependent ALU stalls 16 cycles.
      do_reset();
      issue_fu(1, 5'd7, 5'd1, 5'd2, 0);
      #1 check("B issue div", fu_issue, 1);
      alu(5'd8, 5'd7, 5'd3, 0);
      wait_accept(40, n);
      check("B stall count", n, 16);
      check("B stall_cycles", stall_cycles, 16);
      idle();

      // Structural then back-to-back MUL.
      do_reset();
      issue_fu(0, 5'd3, 5'd1, 5'd2, 0);
      issue_fu(0, 5'd4, 5'd1, 5'd2, 0);
      wait_accept(10, n);
      check("C struct stalls", n, 2);
      check("C b2b issue", fu_issue, 1);
      check("C complete rd3", fu_complete, 1);
      check("C fu_rd 3", fu_rd, 3);
      idle(); idle();
      idle(); #1 check("C complete rd4", fu_complete, 1);
      check("C fu_rd 4", fu_rd, 4);
      idle();

      // x0 never hazards; WAW on rd=9 stalls through DONE.
      do_reset();
      issue_fu(1, 5'd0, 5'd1, 5'd2, 0);
      alu(5'd0, 5'd0, 5'd0, 0);
      #1 check("D x0 no stall", stall, 0);
      check("D x0 busy", fu_busy, 1);
      repeat (18) idle();
      issue_fu(1, 5'd9, 5'd1, 5'd2, 0);
      alu(5'd9, 5'd3, 5'd4, 0);
      wait_accept(40, n);
      check("D waw stalls", n, 16);
      idle();

      // Flush suppresses stall and issue; in-flight op completes on time.
      do_reset();
      issue_fu(0, 5'd6, 5'd1, 5'd2, 0);
      alu(5'd8, 5'd6, 5'd2, 1);
      #1 check("E flush raw stall", stall, 0);
      issue_fu(0, 5'd10, 5'd1, 5'd2, 1);
      #1 check("E flush struct stall", stall, 0);
      check("E flush struct issue", fu_issue, 0);
      issue_fu(0, 5'd11, 5'd1, 5'd2, 1);
      #1 check("E flush done complete", fu_complete, 1);
      check("E flush done issue", fu_issue, 0);
      idle(); #1 check("E idle after", fu_busy, 0);
      check("E stall_cycles", stall_cycles, 0);

      // Async reset mid-DIV abandons the op.
      do_reset();
      issue_fu(1, 5'd12, 5'd1, 5'd2, 0);
      repeat (3) alu(5'd8, 5'd12, 5'd2, 0);
      idle();
      idle();
      #1 check("F pre busy", fu_busy, 1);
      check("F pre stall_cycles", stall_cycles, 3);
      #1 reset = 1'b0;
      #1 check("F rst busy", fu_busy, 0);
      check("F rst stall_cycles", stall_cycles, 0);
      check("F rst complete", fu_complete, 0);
      @(posedge clk); #1 reset = 1'b1;
      seen = 0;
      repeat (20) begin
         idle();
         #1 if (fu_complete) seen++;
      end
      check("F no late complete", seen, 0);
      issue_fu(0, 5'd13, 5'd1, 5'd2, 0);
      #1 check("F new issue", fu_issue, 1);
      idle(); idle();
      idle(); #1 check("F new complete", fu_complete, 1);
      check("F new rd", fu_rd, 13);
      idle(); idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
